// File: rtl/digpot_pkg.sv
// Shared types and defaults for the X9C-series digital potentiometer stepper.
package digpot_pkg;

    localparam int MAX_POS_DEF    = 99;
    localparam int POS_W_DEF      = 7;
    localparam int HOME_STEPS_DEF = 100;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_PULSE_LO   = 3'd2,
        ST_PULSE_HI   = 3'd3,
        ST_DESEL      = 3'd4,
        ST_HOME_SETUP = 3'd5
    } state_e;

    // Pin levels with the device deselected and the wiper untouched
    localparam logic PIN_CS_N_IDLE  = 1'b1;
    localparam logic PIN_INC_N_IDLE = 1'b1;
    localparam logic PIN_UD_RESET   = 1'b0;

endpackage

// File: rtl/digpot_tick_edge.sv
// Turns the divider output level into a one-clk tick on every edge of tick_in.
module digpot_tick_edge (
    input  logic clk,
    input  logic tick_in,
    output logic tick
);

    logic tick_in_q;

    // Left unreset so it tracks tick_in while rst is held and no false tick appears on release
    always_ff @(posedge clk) begin
        tick_in_q <= tick_in;
    end

    assign tick = tick_in ^ tick_in_q;

endmodule

// File: rtl/digpot_stepper.sv
// Steps an X9C up/down pot toward a requested wiper position, homing it after reset.
// Build option DIGPOT_NVSTORE_EN: deselect with inc_n high so the device stores the wiper.
module digpot_stepper
    import digpot_pkg::*;
#(
    parameter int MAX_POS    = MAX_POS_DEF,
    parameter int POS_W      = POS_W_DEF,
    parameter int HOME_STEPS = HOME_STEPS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             tgt_valid,
    input  logic [POS_W-1:0] tgt_pos,
    output logic             tgt_ready,
    output logic [POS_W-1:0] cur_pos,
    output logic             busy,
    output logic             homed,
    output logic             done_pulse,
    output logic             cs_n,
    output logic             inc_n,
    output logic             ud
);

    localparam int CNT_W = $clog2(HOME_STEPS + 1);
    localparam logic [POS_W-1:0] MAX_POS_V = POS_W'(MAX_POS);

    logic tick;

    digpot_tick_edge u_tick_edge (
        .clk    (clk),
        .tick_in(tick_in),
        .tick   (tick)
    );

    state_e             state_q, state_d;
    logic               cs_n_q, cs_n_d;
    logic               inc_n_q, inc_n_d;
    logic               ud_q, ud_d;
    logic               done_q, done_d;
    logic               homed_q, homed_d;
    logic               homing_q, homing_d;
    logic [POS_W-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    logic [POS_W-1:0]   tgt_clamp;
    logic               accept;

    assign tgt_clamp = (tgt_pos > MAX_POS_V) ? MAX_POS_V : tgt_pos;
    assign tgt_ready = (state_q == ST_IDLE) && homed_q;
    assign accept    = tgt_valid && tgt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HOME_SETUP;
            cs_n_q   <= PIN_CS_N_IDLE;
            inc_n_q  <= PIN_INC_N_IDLE;
            ud_q     <= PIN_UD_RESET;
            done_q   <= 1'b0;
            homed_q  <= 1'b0;
            homing_q <= 1'b1;
            cur_q    <= '0;
            rem_q    <= CNT_W'(HOME_STEPS);
        end else begin
            state_q  <= state_d;
            cs_n_q   <= cs_n_d;
            inc_n_q  <= inc_n_d;
            ud_q     <= ud_d;
            done_q   <= done_d;
            homed_q  <= homed_d;
            homing_q <= homing_d;
            cur_q    <= cur_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cs_n_d   = cs_n_q;
        inc_n_d  = inc_n_q;
        ud_d     = ud_q;
        done_d   = 1'b0;
        homed_d  = homed_q;
        homing_d = homing_q;
        cur_d    = cur_q;
        rem_d    = rem_q;

        case (state_q)
            ST_IDLE: begin
                cs_n_d  = PIN_CS_N_IDLE;
                inc_n_d = PIN_INC_N_IDLE;
                if (accept) begin
                    if (tgt_clamp == cur_q) begin
                        done_d = 1'b1;
                    end else if (tgt_clamp > cur_q) begin
                        ud_d    = 1'b1;
                        rem_d   = CNT_W'(tgt_clamp - cur_q);
                        state_d = ST_SETUP;
                    end else begin
                        ud_d    = 1'b0;
                        rem_d   = CNT_W'(cur_q - tgt_clamp);
                        state_d = ST_SETUP;
                    end
                end
            end

            ST_HOME_SETUP: begin
                // Drive the wiper down far enough to hit the bottom stop from any position
                if (tick) begin
                    ud_d     = 1'b0;
                    rem_d    = CNT_W'(HOME_STEPS);
                    homing_d = 1'b1;
                    cs_n_d   = 1'b0;
                    state_d  = ST_PULSE_LO;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    cs_n_d  = 1'b0;
                    state_d = ST_PULSE_LO;
                end
            end

            ST_PULSE_LO: begin
                if (tick) begin
                    inc_n_d = 1'b0;
                    rem_d   = rem_q - CNT_W'(1);
                    if (ud_q) begin
                        if (cur_q < MAX_POS_V) cur_d = cur_q + 1'b1;
                    end else begin
                        if (cur_q != '0) cur_d = cur_q - 1'b1;
                    end
                    state_d = ST_PULSE_HI;
                end
            end

            ST_PULSE_HI: begin
                if (tick) begin
                    inc_n_d = 1'b1;
                    state_d = (rem_q == '0) ? ST_DESEL : ST_PULSE_LO;
                end
            end

            ST_DESEL: begin
                if (tick) begin
`ifdef DIGPOT_NVSTORE_EN
                    cs_n_d  = 1'b1;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (homing_q) begin
                        homed_d  = 1'b1;
                        homing_d = 1'b0;
                    end
`else
                    // inc_n must already be low when cs_n rises, otherwise the device stores
                    if (inc_n_q) begin
                        inc_n_d = 1'b0;
                    end else begin
                        cs_n_d  = 1'b1;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (homing_q) begin
                            homed_d  = 1'b1;
                            homing_d = 1'b0;
                        end
                    end
`endif
                end
            end

            default: begin
                state_d = ST_HOME_SETUP;
            end
        endcase
    end

    assign cur_pos    = cur_q;
    assign busy       = (state_q != ST_IDLE);
    assign homed      = homed_q;
    assign done_pulse = done_q;
    assign cs_n       = cs_n_q;
    assign inc_n      = inc_n_q;
    assign ud         = ud_q;

endmodule

// File: tb/tb_digpot_stepper.sv
// Directed bench for digpot_stepper: homing, table of moves, equal target, reset mid-move.
module tb_digpot_stepper;

    localparam int POS_W    = 7;
    localparam int TICK_DIV = 4;
`ifdef DIGPOT_NVSTORE_EN
    localparam int   EXTRA       = 0;
    localparam logic INC_AT_RISE = 1'b1;
`else
    localparam int   EXTRA       = 1;
    localparam logic INC_AT_RISE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick_in = 1'b0;
    logic             tgt_valid = 1'b0;
    logic [POS_W-1:0] tgt_pos = '0;
    logic             tgt_ready;
    logic [POS_W-1:0] cur_pos;
    logic             busy, homed, done_pulse, cs_n, inc_n, ud;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   tick_cnt = 0;
    logic tick_prev = 1'b0;

    digpot_stepper dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .tgt_valid (tgt_valid),
        .tgt_pos   (tgt_pos),
        .tgt_ready (tgt_ready),
        .cur_pos   (cur_pos),
        .busy      (busy),
        .homed     (homed),
        .done_pulse(done_pulse),
        .cs_n      (cs_n),
        .inc_n     (inc_n),
        .ud        (ud)
    );

    always #5 clk = ~clk;

    always begin
        repeat (TICK_DIV) @(posedge clk);
        #1;
        tick_in = ~tick_in;
    end

    // Counts the ticks the DUT sees at each clock edge
    always @(posedge clk) begin
        if (tick_in != tick_prev) tick_cnt <= tick_cnt + 1;
        tick_prev <= tick_in;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_accept(input logic [POS_W-1:0] pos, output bit ok);
        logic r;
        ok = 1'b0;
        tgt_pos   = pos;
        tgt_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            r = tgt_ready;
            @(posedge clk);
            #1;
            ok = r;
        end
        tgt_valid = 1'b0;
    endtask

    task automatic run_seq(input bit acc, input logic [POS_W-1:0] pos, input bit mid_req,
                           input logic exp_ud, output int falls, output int ticks,
                           output int dones, output int bad_ud, output int cs_hi_falls,
                           output int inc_rise, output int ready_seen, output bit timeout);
        bit   ok, fin, saw_low;
        logic inc_prev, cs_prev;
        int   t0, t;
        falls = 0; ticks = -1; dones = 0; bad_ud = 0; cs_hi_falls = 0;
        inc_rise = -1; ready_seen = 0; timeout = 1'b0;
        fin = 1'b0; saw_low = 1'b0;
        if (acc) begin
            do_accept(pos, ok);
            if (!ok) timeout = 1'b1;
        end
        t0 = tick_cnt;
        inc_prev = inc_n;
        cs_prev  = cs_n;
        for (int cyc = 0; cyc < 3000 && !fin && !timeout; cyc++) begin
            @(posedge clk);
            #1;
            if (mid_req) begin
                t = tick_cnt - t0;
                if (t >= 10 && t < 60) begin
                    tgt_pos   = 7'd50;
                    tgt_valid = 1'b1;
                end else begin
                    tgt_valid = 1'b0;
                end
                if (tgt_valid && tgt_ready) ready_seen++;
            end
            if (done_pulse) dones++;
            if (inc_prev && !inc_n) begin
                falls++;
                if (ud !== exp_ud) bad_ud++;
                if (cs_n) cs_hi_falls++;
            end
            if (!cs_n) saw_low = 1'b1;
            if (saw_low && cs_n && !cs_prev) begin
                fin      = 1'b1;
                ticks    = tick_cnt - t0;
                inc_rise = int'(inc_n);
            end
            inc_prev = inc_n;
            cs_prev  = cs_n;
        end
        tgt_valid = 1'b0;
        if (!fin) timeout = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_pulse) dones++;
        end
    endtask

    typedef struct {
        logic [POS_W-1:0] pos;
        bit               mid;
        logic             exp_ud;
        int               exp_falls;
        int               exp_ticks;
        int               exp_pos;
    } vec_t;

    task automatic check_homing(input string tag);
        int falls, ticks, dones, bad_ud, cs_hi, inc_r, rdy;
        bit to;
        run_seq(1'b0, '0, 1'b0, 1'b0, falls, ticks, dones, bad_ud, cs_hi, inc_r, rdy, to);
        check({tag, "_timeout"}, int'(to), 0);
        check({tag, "_falls"}, falls, 100 + EXTRA);
        check({tag, "_ticks"}, ticks, 202 + EXTRA);
        check({tag, "_ud_down"}, bad_ud, 0);
        check({tag, "_inc_at_cs_rise"}, inc_r, int'(INC_AT_RISE));
        check({tag, "_done_once"}, dones, 1);
        check({tag, "_homed"}, int'(homed), 1);
        check({tag, "_cur_pos"}, int'(cur_pos), 0);
        check({tag, "_ready"}, int'(tgt_ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        vec_t vecs[3];
        int   falls, ticks, dones, bad_ud, cs_hi, inc_r, rdy, seen, pin_changes, f;
        bit   to, ok;
        logic cs0, inc0, ud0, inc_p;

        // 127 is the largest encodable request and must clamp to 99
        vecs[0] = '{7'd25,  1'b0, 1'b1, 25 + EXTRA,  52 + EXTRA, 25};
        vecs[1] = '{7'd127, 1'b0, 1'b1, 74 + EXTRA, 150 + EXTRA, 99};
        vecs[2] = '{7'd10,  1'b1, 1'b0, 89 + EXTRA, 180 + EXTRA, 10};

        repeat (5) @(posedge clk);
        #1;
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_inc_n", int'(inc_n), 1);
        check("rst_ud", int'(ud), 0);
        check("rst_cur_pos", int'(cur_pos), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_homed", int'(homed), 0);
        check("rst_ready", int'(tgt_ready), 0);
        check("rst_done", int'(done_pulse), 0);

        rst = 1'b0;
        check_homing("home1");

        for (int i = 0; i < 3; i++) begin
            run_seq(1'b1, vecs[i].pos, vecs[i].mid, vecs[i].exp_ud,
                    falls, ticks, dones, bad_ud, cs_hi, inc_r, rdy, to);
            check($sformatf("v%0d_timeout", i), int'(to), 0);
            check($sformatf("v%0d_falls", i), falls, vecs[i].exp_falls);
            check($sformatf("v%0d_ticks", i), ticks, vecs[i].exp_ticks);
            check($sformatf("v%0d_ud", i), bad_ud, 0);
            check($sformatf("v%0d_cs_low_on_falls", i), cs_hi, 0);
            check($sformatf("v%0d_inc_at_cs_rise", i), inc_r, int'(INC_AT_RISE));
            check($sformatf("v%0d_done_once", i), dones, 1);
            check($sformatf("v%0d_ready_mid", i), rdy, 0);
            check($sformatf("v%0d_cur_pos", i), int'(cur_pos), vecs[i].exp_pos);
            check($sformatf("v%0d_busy", i), int'(busy), 0);

            if (i == 1) begin
                // Request the current position: immediate done, no pin activity
                do_accept(7'd99, ok);
                check("eq_accept", int'(ok), 1);
                check("eq_done_next_cycle", int'(done_pulse), 1);
                check("eq_busy", int'(busy), 0);
                cs0 = cs_n; inc0 = inc_n; ud0 = ud;
                pin_changes = 0;
                seen = 0;
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk);
                    #1;
                    if (done_pulse) seen++;
                    if (cs_n !== cs0 || inc_n !== inc0 || ud !== ud0) pin_changes++;
                end
                check("eq_done_one_cycle", seen, 0);
                check("eq_pin_changes", pin_changes, 0);
                check("eq_cur_pos", int'(cur_pos), 99);
            end
        end

        // Reset while the FSM waits in PULSE_LO of a move from 10 toward 60
        do_accept(7'd60, ok);
        check("rmid_accept", int'(ok), 1);
        f = 0;
        inc_p = inc_n;
        to = 1'b1;
        for (int c = 0; c < 2000 && to; c++) begin
            @(posedge clk);
            #1;
            if (inc_p && !inc_n) f++;
            inc_p = inc_n;
            if (f >= 2 && !cs_n && inc_n) to = 1'b0;
        end
        check("rmid_reach_pulse_lo", int'(to), 0);
        rst = 1'b1;
        #1;
        check("rmid_cs_n", int'(cs_n), 1);
        check("rmid_inc_n", int'(inc_n), 1);
        check("rmid_homed", int'(homed), 0);
        check("rmid_busy", int'(busy), 1);
        check("rmid_cur_pos", int'(cur_pos), 0);
        check("rmid_ready", int'(tgt_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_homing("home2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
